apb_master_bridge: RTL and testbench

//  CPU-side load/store to APB3 master bridge; drives PADDR/PSEL/PENABLE/PWRITE/PWDATA of the

---
 rtl/apb_master_bridge.sv | 155 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// CPU load/store to APB3 master bridge with slave decode, PREADY timeout and error return.
// Latency: zero-wait slave responds 3 cycles after accept; each PREADY wait cycle adds one.
// Backpressure: one transfer in flight; req_ready is high only in IDLE, so the CPU holds its request.
module apb_master_bridge #(
  parameter int NUM_SLAVES = 3,
  parameter int SEL_LSB    = 12,
  parameter int SEL_BITS   = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [31:0]              PADDR,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY_s,
  input  logic [NUM_SLAVES*32-1:0] PRDATA_s,
  input  logic [NUM_SLAVES-1:0]    PSLVERR_s
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [SEL_BITS-1:0]     req_idx, cur_idx;
  logic                    accept, req_mapped, timed_out;
  logic                    sel_ready, sel_err;
  logic [31:0]             sel_rdata;
  logic                    req_ready_nxt, rsp_valid_nxt, rsp_err_nxt, penable_nxt, pwrite_nxt;
  logic [31:0]             rsp_rdata_nxt, paddr_nxt, pwdata_nxt;
  logic [NUM_SLAVES-1:0]   psel_nxt;

  function automatic logic [NUM_SLAVES-1:0] onehot(input logic [SEL_BITS-1:0] idx);
    logic [NUM_SLAVES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      v[i] = (int'(idx) == i);
    end
    return v;
  endfunction

  // The slave index of an in-flight transfer comes from the latched PADDR, not the live request.
  assign req_idx    = req_addr[SEL_LSB+SEL_BITS-1:SEL_LSB];
  assign cur_idx    = PADDR[SEL_LSB+SEL_BITS-1:SEL_LSB];
  assign accept     = req_valid & req_ready;
  assign req_mapped = (int'(req_idx) < NUM_SLAVES);
  assign timed_out  = (cnt == CW'(TIMEOUT - 1));

  // Return-path mux for the currently selected slave; unselected slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(cur_idx) == i) begin
        sel_ready = PREADY_s[i];
        sel_err   = PSLVERR_s[i];
        sel_rdata = PRDATA_s[32*i +: 32];
      end
    end
  end

  // State register; reset mid-transfer simply abandons the transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; PREADY takes priority over the timeout on the final wait cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = req_mapped ? S_SETUP : S_ERR;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (sel_ready || timed_out) state_nxt = S_DONE;
      S_ERR:    state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values for every registered output, derived from the transition being taken.
  always_comb begin
    req_ready_nxt = (state_nxt == S_IDLE);
    rsp_valid_nxt = (state_nxt == S_DONE);
    penable_nxt   = (state_nxt == S_ACCESS);
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    paddr_nxt     = PADDR;
    pwdata_nxt    = PWDATA;
    pwrite_nxt    = PWRITE;
    psel_nxt      = '0;
    cnt_nxt       = cnt;
    if (accept) begin
      paddr_nxt  = req_addr;
      pwdata_nxt = req_wdata;
      pwrite_nxt = req_write;
    end
    if (state == S_IDLE && state_nxt == S_SETUP) psel_nxt = onehot(req_idx);
    else if (state_nxt == S_ACCESS)               psel_nxt = PSEL;
    if (state_nxt == S_SETUP) begin
      cnt_nxt = '0;
    end else if (state == S_ACCESS && !sel_ready && !timed_out) begin
      cnt_nxt = cnt + CW'(1);
    end
    if (state_nxt == S_DONE) begin
      if (state == S_ACCESS && sel_ready) begin
        rsp_rdata_nxt = PWRITE ? 32'h0 : sel_rdata;
        rsp_err_nxt   = sel_err;
      end else begin
        rsp_rdata_nxt = 32'h0;
        rsp_err_nxt   = 1'b1;
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      cnt       <= '0;
    end else begin
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      PADDR     <= paddr_nxt;
      PSEL      <= psel_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PWDATA    <= pwdata_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: decode, wait states, slave error, timeout, unmapped, reset abort.
// Inputs are driven 1 time unit after the rising edge and outputs are checked at that same point.
// Expected values are hand-computed constants for TIMEOUT=4 and three slaves.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic [2:0]  PSEL;
  logic        PENABLE, PWRITE;
  logic [2:0]  PREADY_s, PSLVERR_s;
  logic [95:0] PRDATA_s;

  int tests_run    = 0;
  int tests_failed = 0;

  apb_master_bridge #(.NUM_SLAVES(3), .SEL_LSB(12), .SEL_BITS(2), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY_s(PREADY_s), .PRDATA_s(PRDATA_s), .PSLVERR_s(PSLVERR_s)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Presents a request for exactly one cycle (accepted at the next edge, since bench keeps it IDLE).
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
  endtask

  initial begin
    int en_cycles;
    int waited;
    PRESETn   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY_s  = '0;
    PSLVERR_s = '0;
    PRDATA_s  = '0;
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_psel",      32'(PSEL), 32'd0);
    chk("rst_penable",   32'(PENABLE), 32'd0);
    chk("rst_paddr",     PADDR, 32'h0);
    chk("rst_pwdata",    PWDATA, 32'h0);
    chk("rst_pwrite",    32'(PWRITE), 32'd0);
    PRESETn = 1'b1;
    step();

    // 1: zero-wait write to slave1
    PREADY_s = 3'b010;
    issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
    chk("t1_T1_psel",    32'(PSEL), 32'b010);
    chk("t1_T1_penable", 32'(PENABLE), 32'd0);
    chk("t1_T1_paddr",   PADDR, 32'h0000_1004);
    chk("t1_T1_pwdata",  PWDATA, 32'hDEAD_BEEF);
    chk("t1_T1_pwrite",  32'(PWRITE), 32'd1);
    chk("t1_T1_ready",   32'(req_ready), 32'd0);
    chk("t1_T1_rspv",    32'(rsp_valid), 32'd0);
    step();
    chk("t1_T2_psel",    32'(PSEL), 32'b010);
    chk("t1_T2_penable", 32'(PENABLE), 32'd1);
    step();
    chk("t1_T3_rspv",    32'(rsp_valid), 32'd1);
    chk("t1_T3_err",     32'(rsp_err), 32'd0);
    chk("t1_T3_rdata",   rsp_rdata, 32'h0);
    chk("t1_T3_psel",    32'(PSEL), 32'd0);
    chk("t1_T3_penable", 32'(PENABLE), 32'd0);
    step();
    chk("t1_T4_rspv",    32'(rsp_valid), 32'd0);
    chk("t1_T4_ready",   32'(req_ready), 32'd1);
    chk("t1_T4_paddr_hold", PADDR, 32'h0000_1004);

    // 2: read slave0 with three wait cycles; slave1 ready and junk data must be ignored
    PREADY_s = 3'b010;
    PRDATA_s[31:0]  = 32'h0BAD_0BAD;
    PRDATA_s[63:32] = 32'h5555_AAAA;
    issue(1'b0, 32'h0000_0008, 32'h0);
    chk("t2_T1_psel",  32'(PSEL), 32'b001);
    chk("t2_T1_pwrite", 32'(PWRITE), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("t2_T%0d_penable", k), 32'(PENABLE), 32'd1);
      chk($sformatf("t2_T%0d_paddr", k), PADDR, 32'h0000_0008);
      chk($sformatf("t2_T%0d_rspv", k), 32'(rsp_valid), 32'd0);
    end
    PREADY_s[0]    = 1'b1;
    PRDATA_s[31:0] = 32'h1234_5678;
    step();
    PREADY_s       = '0;
    PRDATA_s[31:0] = 32'h0;
    chk("t2_T6_rspv",  32'(rsp_valid), 32'd1);
    chk("t2_T6_rdata", rsp_rdata, 32'h1234_5678);
    chk("t2_T6_err",   32'(rsp_err), 32'd0);
    step();
    chk("t2_T7_rspv",  32'(rsp_valid), 32'd0);
    chk("t2_T7_rdata_hold", rsp_rdata, 32'h1234_5678);

    // 3: read slave2 with PSLVERR
    PREADY_s  = 3'b100;
    PSLVERR_s = 3'b100;
    PRDATA_s[95:64] = 32'hCAFE_0001;
    issue(1'b0, 32'h0000_2010, 32'h0);
    chk("t3_T1_psel", 32'(PSEL), 32'b100);
    step();
    chk("t3_T2_penable", 32'(PENABLE), 32'd1);
    step();
    chk("t3_T3_rspv",  32'(rsp_valid), 32'd1);
    chk("t3_T3_err",   32'(rsp_err), 32'd1);
    chk("t3_T3_rdata", rsp_rdata, 32'hCAFE_0001);
    step();
    chk("t3_T4_rspv",  32'(rsp_valid), 32'd0);
    PREADY_s  = '0;
    PSLVERR_s = '0;

    // 4: timeout on slave0, PREADY stuck low
    issue(1'b0, 32'h0000_0040, 32'h0);
    chk("t4_T1_psel", 32'(PSEL), 32'b001);
    en_cycles = 0;
    waited    = 0;
    while (!rsp_valid && waited < 20) begin
      step();
      waited++;
      if (PENABLE) en_cycles++;
    end
    chk("t4_rsp_seen",   32'(rsp_valid), 32'd1);
    chk("t4_en_cycles",  32'(en_cycles), 32'd4);
    chk("t4_err",        32'(rsp_err), 32'd1);
    chk("t4_rdata",      rsp_rdata, 32'h0);
    chk("t4_psel_after", 32'(PSEL), 32'd0);
    step();

    // 5: unmapped index 3
    PREADY_s = 3'b111;
    issue(1'b0, 32'h0000_3000, 32'h0);
    chk("t5_T1_psel",    32'(PSEL), 32'd0);
    chk("t5_T1_penable", 32'(PENABLE), 32'd0);
    chk("t5_T1_rspv",    32'(rsp_valid), 32'd0);
    step();
    chk("t5_T2_rspv",  32'(rsp_valid), 32'd1);
    chk("t5_T2_err",   32'(rsp_err), 32'd1);
    chk("t5_T2_rdata", rsp_rdata, 32'h0);
    chk("t5_T2_psel",  32'(PSEL), 32'd0);
    step();
    PREADY_s = '0;

    // 6: reset during ACCESS, then a normal write
    issue(1'b1, 32'h0000_1000, 32'h1111_2222);
    step();
    chk("t6_access_penable", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    chk("t6_rst_psel",    32'(PSEL), 32'd0);
    chk("t6_rst_penable", 32'(PENABLE), 32'd0);
    chk("t6_rst_rspv",    32'(rsp_valid), 32'd0);
    step();
    step();
    #2 PRESETn = 1'b1;
    step();
    chk("t6_ready_after", 32'(req_ready), 32'd1);
    chk("t6_no_rsp",      32'(rsp_valid), 32'd0);
    PREADY_s = 3'b010;
    issue(1'b1, 32'h0000_1008, 32'hA5A5_5A5A);
    chk("t6_T1_psel",   32'(PSEL), 32'b010);
    chk("t6_T1_pwdata", PWDATA, 32'hA5A5_5A5A);
    step();
    chk("t6_T2_penable", 32'(PENABLE), 32'd1);
    step();
    chk("t6_T3_rspv", 32'(rsp_valid), 32'd1);
    chk("t6_T3_err",  32'(rsp_err), 32'd0);
    step();
    chk("t6_T4_ready", 32'(req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
